// File: rtl/logger_fifo_gen.sv
// Synchronous logger FIFO with FWFT or standard read mode, occupancy count and programmable flags.
// Optional occupancy/drop statistics are compiled in with LOGGER_FIFO_STATS_EN.
module logger_fifo_gen #(
   parameter int unsigned WIDTH             = 8,
   parameter int unsigned DEPTH             = 256,
   parameter int unsigned PROG_FULL_THRESH  = DEPTH - 56,
   parameter int unsigned PROG_EMPTY_THRESH = 4,
   parameter int unsigned FWFT              = 1,
   localparam int unsigned AW               = $clog2(DEPTH),
   localparam int unsigned CW               = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             prog_full,
   output logic             overflow,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic             empty,
   output logic             prog_empty,
   output logic             underflow,
   output logic [CW-1:0]    count
`ifdef LOGGER_FIFO_STATS_EN
   ,
   output logic [CW-1:0]    max_count,
   output logic [15:0]      drop_count
`endif
);

   if (DEPTH < 4 || DEPTH > 4096 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("logger_fifo_gen: DEPTH must be a power of two in 4..4096");
   end
   if (PROG_FULL_THRESH < 1 || PROG_FULL_THRESH > DEPTH) begin : g_bad_pfull
      $error("logger_fifo_gen: PROG_FULL_THRESH out of range");
   end
   if (PROG_EMPTY_THRESH > DEPTH - 1) begin : g_bad_pempty
      $error("logger_fifo_gen: PROG_EMPTY_THRESH out of range");
   end
   if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $error("logger_fifo_gen: WIDTH out of range");
   end

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [CW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dout_valid_q, dout_valid_d;
   logic             full_q, empty_q, prog_full_q, prog_empty_q;
   logic             overflow_q, underflow_q;
   logic             wr_acc, rd_acc;
   logic [AW-1:0]    rd_addr_nxt;

   // Accept decisions use the flags registered at the start of the cycle
   always_comb begin
      wr_acc      = wr_en && !full_q;
      rd_acc      = rd_en && !empty_q;
      wr_ptr_d    = wr_ptr_q + CW'(wr_acc);
      rd_ptr_d    = rd_ptr_q + CW'(rd_acc);
      count_d     = wr_ptr_d - rd_ptr_d;
      rd_addr_nxt = rd_ptr_q[AW-1:0] + AW'(1);
   end

   // FWFT keeps the head word in dout_q; a pop loads its successor, which may be din itself
   always_comb begin
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      if (FWFT != 0) begin
         dout_valid_d = (count_d != '0);
         if (rd_acc) begin
            if (count_q > CW'(1)) begin
               dout_d = mem_q[rd_addr_nxt];
            end else if (wr_acc) begin
               dout_d = din;
            end
         end else if (wr_acc && empty_q) begin
            dout_d = din;
         end
      end else if (rd_acc) begin
         dout_d       = mem_q[rd_ptr_q[AW-1:0]];
         dout_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem_q[wr_ptr_q[AW-1:0]] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         full_q       <= 1'b0;
         empty_q      <= 1'b1;
         prog_full_q  <= 1'(PROG_FULL_THRESH == 0);
         prog_empty_q <= 1'b1;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         full_q       <= (count_d == CW'(DEPTH));
         empty_q      <= (count_d == '0);
         prog_full_q  <= (count_d >= CW'(PROG_FULL_THRESH));
         prog_empty_q <= (count_d <= CW'(PROG_EMPTY_THRESH));
         overflow_q   <= wr_en && full_q;
         underflow_q  <= rd_en && empty_q;
      end
   end

   assign full       = full_q;
   assign prog_full  = prog_full_q;
   assign overflow   = overflow_q;
   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign empty      = empty_q;
   assign prog_empty = prog_empty_q;
   assign underflow  = underflow_q;
   assign count      = count_q;

`ifdef LOGGER_FIFO_STATS_EN
   logic [CW-1:0] max_count_q, max_count_d;
   logic [15:0]   drop_count_q, drop_count_d;

   // Watermark trails count by one cycle; drop counter saturates
   always_comb begin
      max_count_d  = (count_q > max_count_q) ? count_q : max_count_q;
      drop_count_d = drop_count_q;
      if (wr_en && full_q && (drop_count_q != 16'hFFFF)) begin
         drop_count_d = drop_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         max_count_q  <= '0;
         drop_count_q <= '0;
      end else begin
         max_count_q  <= max_count_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign max_count  = max_count_q;
   assign drop_count = drop_count_q;
`endif

endmodule
